// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the burst-locked FIFO write arbiter: FSM state
// encoding and the round-robin pointer advance.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Next search start after owner ptr; the explicit wrap keeps it correct
  // for non-power-of-2 producer counts.
  function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
    int unsigned inc;
    inc = ptr + 1;
    return (inc >= n) ? 0 : inc;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Circular-priority encoder: returns the first set request bit found when
// searching from i_rr_ptr upwards, wrapping modulo NUM_REQ.
module rr_priority_picker #(
  parameter int NUM_REQ  = 3,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_rr_ptr,
  output logic                o_found,
  output logic [ID_WIDTH-1:0] o_winner
);

  localparam logic [ID_WIDTH:0] N_W = (ID_WIDTH+1)'(NUM_REQ);

  logic [ID_WIDTH:0] w_sum;
  logic [ID_WIDTH:0] w_idx;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    o_found  = 1'b0;
    o_winner = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr + k never exceeds 2*NUM_REQ-2, so one extra bit holds the sum
      w_sum = {1'b0, i_rr_ptr} + (ID_WIDTH+1)'(k);
      w_idx = (w_sum >= N_W) ? (w_sum - N_W) : w_sum;
      if (!o_found && i_req[w_idx[ID_WIDTH-1:0]]) begin
        o_found  = 1'b1;
        o_winner = w_idx[ID_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port between
// NUM_REQ producers; each grant lasts exactly BURST_LEN accepted beats.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int NUM_REQ    = 3,
  parameter  int BURST_LEN  = 4,
  localparam int ID_WIDTH   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_write_request,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full_flag,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy,
  output logic                          burst_done
);

  localparam int                CNT_W     = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t              r_state;
  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic [ID_WIDTH-1:0] r_grant_id;
  logic [CNT_W-1:0]    r_beat_cnt;

  logic                w_found;
  logic [ID_WIDTH-1:0] w_winner;
  logic                w_busy;
  logic                w_xfer;
  logic                w_last;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(ID_WIDTH)
  ) u_picker (
    .i_req   (req_valid),
    .i_rr_ptr(r_rr_ptr),
    .o_found (w_found),
    .o_winner(w_winner)
  );

  // Outputs are qualified by reset so nothing is written in the reset cycle,
  // even when the clear lands mid-burst.
  assign w_busy = reset && (r_state == BURST);
  assign w_xfer = w_busy && req_valid[r_grant_id] && !fifo_full_flag;
  assign w_last = w_xfer && (r_beat_cnt == LAST_BEAT);

  assign fifo_write_request = w_xfer;
  assign busy               = w_busy;
  assign burst_done         = w_last;
  assign grant_id           = reset ? r_grant_id : '0;
  assign fifo_wr_data       = w_busy ? req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_comb begin
    req_ready = '0;
    if (w_busy && !fifo_full_flag) req_ready[r_grant_id] = 1'b1;
  end

  // NOTE: state uses non-blocking assignments and a synchronous active-low
  // clear sampled at the clock edge, so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_id <= w_winner;
            r_beat_cnt <= '0;
            r_state    <= BURST;
          end
        end
        BURST: begin
          if (w_last) begin
            r_beat_cnt <= '0;
            r_rr_ptr   <= ID_WIDTH'(next_rr(int'(r_grant_id), NUM_REQ));
            r_state    <= IDLE;
          end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares one width-converting PE FIFO write port between NUM_REQ producers (ifmap, filter, psum loaders).
- Grants are burst-locked: a granted producer keeps the port for exactly BURST_LEN accepted beats, so sub-word packing inside the FIFO is never interleaved between producers.
- Sits between the producer valid/ready interfaces and the FIFO's write_request/wr_data/full_flag.

Parameters:
- DATA_WIDTH, 64, width of each producer word and of the FIFO write data.
- NUM_REQ, 3, number of producers (>=2).
- BURST_LEN, 4, beats per grant (>=1).
- ID_WIDTH, max(1,$clog2(NUM_REQ)), derived localparam; not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 clears state at the clock edge).
- req_valid  input  NUM_REQ  per-producer data valid.
- req_data  input  NUM_REQ*DATA_WIDTH  producer words; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-producer accept.
- fifo_write_request  output  1  write strobe to the FIFO.
- fifo_wr_data  output  DATA_WIDTH  write data to the FIFO.
- fifo_full_flag  input  1  FIFO full.
- grant_id  output  ID_WIDTH  current owner index.
- busy  output  1  high while in BURST.
- burst_done  output  1  one-cycle pulse on the last beat of a burst.

Behaviour:
- Reset values while reset==0 and on the following cycle:
  - state=IDLE, rr_ptr=0, beat_cnt=0.
  - grant_id=0, busy=0, burst_done=0.
  - req_ready=0, fifo_write_request=0, fifo_wr_data=0.
- Reset mid-burst aborts the burst; no write is issued in the reset cycle, and already-written beats stay in the FIFO.
- Producer word transfer: req_valid[g] && req_ready[g]. The outputs below are combinational from state and inputs.
- IDLE:
  - all req_ready=0, fifo_write_request=0, busy=0.
  - If any req_valid bit is set, pick the first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register it in grant_id, clear beat_cnt and go to BURST next cycle. This gives 1 cycle of arbitration latency.
  - grant_id holds its last value while in IDLE.
- BURST (owner g=grant_id):
  - req_ready[g] = !fifo_full_flag; all other ready bits are 0.
  - fifo_write_request = req_valid[g] && !fifo_full_flag.
  - fifo_wr_data = slice g when busy, else 0.
  - Each transfer increments beat_cnt.
  - On the transfer with beat_cnt==BURST_LEN-1: burst_done=1 the same cycle, rr_ptr<=(g+1) mod NUM_REQ, beat_cnt<=0, state<=IDLE.
- Boundary conditions:
  - One bubble cycle always separates bursts, including when the same or another producer is waiting.
  - fifo_full_flag high stalls the burst: no write, beat_cnt holds, and the grant holds indefinitely.
  - The owner dropping req_valid mid-burst stalls without releasing the grant; there is no timeout.
  - Non-owner req_valid is ignored during BURST.
  - rr_ptr wraps from NUM_REQ-1 to 0; the modulo must be correct for non-power-of-2 NUM_REQ.
  - Fairness: with all producers continuously valid, grants cycle 0,1,...,NUM_REQ-1,0.
  - BURST_LEN==1: every transfer asserts burst_done.
- Width rules:
  - beat_cnt is $clog2(BURST_LEN)+1 bits.
  - Index arithmetic is done in ID_WIDTH+1 bits before the modulo.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state encoding (IDLE=1'b0, BURST=1'b1);
  - function next_rr(ptr, n) returning (ptr+1) mod n.
- One sub-module, rr_priority_picker: a combinational circular-priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, winner index.
- The FSM, beat counter and data mux stay in fifo_write_arbiter.

Test Plan:
- Reset priority: reset=0 for 3 cycles with req_valid=3'b111 -> all outputs 0. After reset goes high: grant_id=0 one cycle later, then 4 writes carrying producer 0's words, then burst_done.
- Round robin: req_valid=3'b111 held, fifo_full_flag=0 -> grant sequence 0,1,2,0. Each burst is 4 consecutive fifo_write_request cycles followed by 1 idle cycle, so the period is 5 cycles.
- Backpressure: fifo_full_flag=1 during cycles 2-4 of a producer-1 burst -> req_ready[1]=0 and no writes in those cycles. The burst completes with exactly 4 writes; data order is 0xA0..0xA3 unchanged.
- Owner gap and wrap: only producer 2 valid, valid drops for 2 cycles mid-burst -> grant stays 2 and exactly 4 beats are written. The next winner search starts at 0 (wrap).
- Mid-burst reset: reset=0 after 2 beats of a producer-0 burst -> fifo_write_request=0 that cycle. Afterwards state is IDLE and rr_ptr=0; with req_valid=3'b011 the next grant is 0.
- BURST_LEN=1, NUM_REQ=2 variant: req_valid=2'b11 -> grants alternate 0,1,0,1, with burst_done on every write.
